// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: WIDTH-bit carry chain split into STAGES
// registered segments, with valid/ready handshakes and signed overflow.
module pipelined_adder #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             Cout,
  output logic             ovf
);

  localparam int unsigned SEG = WIDTH / STAGES;

  // Stage registers: index k holds the state after segment k has been added.
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] c_q;
  logic [WIDTH-1:0]  x_q   [STAGES];
  logic [WIDTH-1:0]  ye_q  [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic              ovf_q;

  // Per-stage inputs and next-state values.
  logic [STAGES-1:0] vld_nx;
  logic [STAGES-1:0] src_c;
  logic [STAGES-1:0] c_nx;
  logic [WIDTH-1:0]  src_x   [STAGES];
  logic [WIDTH-1:0]  src_ye  [STAGES];
  logic [WIDTH-1:0]  src_sum [STAGES];
  logic [WIDTH-1:0]  sum_nx  [STAGES];
  logic [SEG:0]      seg_res;
  logic              ovf_nx;
  logic              adv;

  // The whole pipeline advances together whenever the output slot is free.
  assign out_valid = vld_q[STAGES-1];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign sum       = sum_q[STAGES-1];
  assign Cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;

  // Operand routing: stage 0 takes the prepared port operands, later stages
  // take the skewed operands and partial sum from the previous stage.
  always_comb begin
    src_x[0]   = X;
    src_ye[0]  = sub ? ~Y : Y;
    src_c[0]   = Cin ^ sub;
    src_sum[0] = '0;
    vld_nx[0]  = in_valid;
    for (int unsigned k = 1; k < STAGES; k++) begin
      src_x[k]   = x_q[k-1];
      src_ye[k]  = ye_q[k-1];
      src_c[k]   = c_q[k-1];
      src_sum[k] = sum_q[k-1];
      vld_nx[k]  = vld_q[k-1];
    end
  end

  // Segment adders: stage k fills in sum bits [k*SEG +: SEG]; the last stage
  // also derives signed overflow from the delayed operand sign bits.
  always_comb begin
    seg_res = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      seg_res = {1'b0, src_x[k][k*SEG +: SEG]}
              + {1'b0, src_ye[k][k*SEG +: SEG]}
              + {{SEG{1'b0}}, src_c[k]};
      sum_nx[k]                = src_sum[k];
      sum_nx[k][k*SEG +: SEG]  = seg_res[SEG-1:0];
      c_nx[k]                  = seg_res[SEG];
    end
    ovf_nx = (src_x[STAGES-1][WIDTH-1] == src_ye[STAGES-1][WIDTH-1]) &&
             (sum_nx[STAGES-1][WIDTH-1] != src_x[STAGES-1][WIDTH-1]);
  end

  // Pipeline registers: clear on reset, shift on advance, hold on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        x_q[k]   <= '0;
        ye_q[k]  <= '0;
        sum_q[k] <= '0;
      end
    end else if (adv) begin
      vld_q <= vld_nx;
      c_q   <= c_nx;
      ovf_q <= ovf_nx;
      for (int unsigned k = 0; k < STAGES; k++) begin
        x_q[k]   <= src_x[k];
        ye_q[k]  <= src_ye[k];
        sum_q[k] <= sum_nx[k];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed self-checking bench for pipelined_adder (16/4 and 32/1 instances).
module tb_pipelined_adder;

  logic        clk = 1'b0;
  logic        rst_n;

  // WIDTH=16, STAGES=4 instance
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] x, y, sum;

  // WIDTH=32, STAGES=1 instance
  logic        in_valid1, in_ready1, cin1, sub1, out_valid1, out_ready1, cout1, ovf1;
  logic [31:0] x1, y1, sum1;

  int checks   = 0;
  int failures = 0;

  pipelined_adder #(.WIDTH(16), .STAGES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .X(x), .Y(y), .Cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .Cout(cout), .ovf(ovf)
  );

  pipelined_adder #(.WIDTH(32), .STAGES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .X(x1), .Y(y1), .Cin(cin1), .sub(sub1), .out_valid(out_valid1),
    .out_ready(out_ready1), .sum(sum1), .Cout(cout1), .ovf(ovf1)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One isolated op on the 4-stage unit; called at posedge+1 with an empty pipe.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic s, input logic [15:0] es,
                        input logic ec, input logic eo);
    x = a; y = b; cin = c; sub = s; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_early"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_sum"},   64'(sum),       64'(es));
    check({tag, "_cout"},  64'(cout),      64'(ec));
    check({tag, "_ovf"},   64'(ovf),       64'(eo));
    @(posedge clk); #1;
  endtask

  // One op on the single-stage unit: result must be valid one edge later.
  task automatic run_op1(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic c, input logic s, input logic [31:0] es,
                         input logic ec, input logic eo);
    x1 = a; y1 = b; cin1 = c; sub1 = s; in_valid1 = 1'b1; out_ready1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    check({tag, "_valid"}, 64'(out_valid1), 64'd1);
    check({tag, "_sum"},   64'(sum1),       64'(es));
    check({tag, "_cout"},  64'(cout1),      64'(ec));
    check({tag, "_ovf"},   64'(ovf1),       64'(eo));
    @(posedge clk); #1;
    check({tag, "_drain"}, 64'(out_valid1), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          sent;
    int          rcv;
    logic [15:0] held;
    logic        stall;

    // Reset held with operands offered.
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    x = 16'h1234; y = 16'h4321; cin = 1'b1; sub = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b1; x1 = '0; y1 = '0; cin1 = 1'b0; sub1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_sum",   64'(sum),       64'd0);
    check("rst_cout",  64'(cout),      64'd0);
    check("rst_ovf",   64'(ovf),       64'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Directed single ops.
    run_op("ripple",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("sub5_7",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("ovf_neg", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("add_cin", 16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0);
    run_op("sub_brw", 16'h000A, 16'h0003, 1'b1, 1'b1, 16'h0006, 1'b1, 1'b0);

    // Single-stage instance.
    run_op1("s1_ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_op1("s1_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_op1("s1_sub",    32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);

    // Stream of 8 with a 3-cycle output stall mid-stream.
    sent = 0; rcv = 0; held = '0;
    cin = 1'b0; sub = 1'b0;
    for (int cyc = 0; cyc < 40 && rcv < 8; cyc++) begin
      stall     = (cyc >= 5 && cyc < 8);
      out_ready = !stall;
      in_valid  = (sent < 8);
      x         = 16'(sent + 1);
      y         = 16'(3 * (sent + 1));
      #1;
      if (out_valid) begin
        if (stall) begin
          check("stall_in_ready", 64'(in_ready), 64'd0);
          if (cyc == 5) held = sum;
          else check("stall_hold", 64'(sum), 64'(held));
        end else begin
          rcv++;
          check("stream_sum",  64'(sum),  64'(4 * rcv));
          check("stream_cout", 64'(cout), 64'd0);
        end
      end else if (rcv > 0) begin
        check("stream_gap", 64'(out_valid), 64'd1);
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    check("stream_count", 64'(rcv), 64'd8);
    check("stall_value",  64'(held), 64'd8);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Reset with one result at the output and three ops behind it.
    for (int k = 0; k < 4; k++) begin
      x = 16'(16'h0100 * (k + 1)); y = 16'h0011; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("midrst_pre_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_sum",   64'(sum),       64'd0);
    check("midrst_cout",  64'(cout),      64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      check("midrst_stale", 64'(out_valid), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
